// File: rtl/d16_branch_pkg.sv
// d16_branch_pkg: shared definitions for the d16 branch/redirect unit.
//   - D16_OP_* : decoded opcode values for the jump family (JMP/JMZ/JMR are
//                the existing encodings; JNZ/JMN/CALL/RET are new).
//   - ras_cmd_e: per-cycle command issued to the return-address stack.
package d16_branch_pkg;

  localparam logic [7:0] D16_OP_JMP  = 8'h40;
  localparam logic [7:0] D16_OP_JMZ  = 8'h41;
  localparam logic [7:0] D16_OP_JMR  = 8'h42;
  localparam logic [7:0] D16_OP_JNZ  = 8'h43;
  localparam logic [7:0] D16_OP_JMN  = 8'h44;
  localparam logic [7:0] D16_OP_CALL = 8'h45;
  localparam logic [7:0] D16_OP_RET  = 8'h46;

  typedef enum logic [1:0] {
    RAS_NOP  = 2'd0,
    RAS_PUSH = 2'd1,
    RAS_POP  = 2'd2
  } ras_cmd_e;

endpackage

// File: rtl/d16_ras.sv
// d16_ras: circular return-address stack.
//   clk_i, srst_i   : clock and synchronous active-high reset
//   cmd_i           : NOP / PUSH / POP for this cycle (already qualified by the caller)
//   data_i          : value to push
//   top_o           : most recently pushed entry (valid when empty_o = 0)
//   empty_o, full_o : occupancy flags (0 entries / DEPTH entries)
//   ovf_o, unf_o    : sticky push-while-full / pop-while-empty, cleared only by reset
// The stack is small and its top must be visible in the same cycle as the RET
// that consumes it, so it is a register array with an asynchronous read.
module d16_ras
  import d16_branch_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         srst_i,
  input  ras_cmd_e     cmd_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] top_o,
  output logic         empty_o,
  output logic         full_o,
  output logic         ovf_o,
  output logic         unf_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] sp_q, sp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [AW-1:0] top_idx;

  // sp points at the next free slot, so the top lives one below it (mod DEPTH).
  assign top_idx = sp_q - 1'b1;
  assign top_o   = mem_q[top_idx];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    unique case (cmd_i)
      RAS_PUSH: begin
        // A push while full overwrites the oldest slot: sp still advances but
        // the count saturates.
        sp_d = sp_q + 1'b1;
        if (full_o) ovf_d = 1'b1;
        else        cnt_d = cnt_q + 1'b1;
      end
      RAS_POP: begin
        if (empty_o) begin
          unf_d = 1'b1;
        end else begin
          sp_d  = sp_q - 1'b1;
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      sp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Contents are don't-care after reset; only the write is suppressed.
  always_ff @(posedge clk_i) begin
    if (!srst_i && cmd_i == RAS_PUSH) mem_q[sp_q] <= data_i;
  end

endmodule

// File: rtl/d16_branch.sv
// d16_branch: branch/redirect unit with return-address stack.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   valid, op, a, b, pc_next : decoded op, immediate target, condition/register
//                              operand, return address
//   load, mem_addr   : registered one-cycle redirect (mem_addr is 0 when idle)
//   li_di_rst        : flush for fetch/decode = sys_rst | load
//   ras_empty/full   : stack occupancy; ras_ovf/ras_unf sticky stack faults
module d16_branch
  import d16_branch_pkg::*;
#(
  parameter int W         = 16,
  parameter int RAS_DEPTH = 8
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         valid,
  input  logic [7:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] pc_next,
  output logic         li_di_rst,
  output logic [W-1:0] mem_addr,
  output logic         load,
  output logic         ras_empty,
  output logic         ras_full,
  output logic         ras_ovf,
  output logic         ras_unf
);

  localparam int RAS_AW = $clog2(RAS_DEPTH);

  logic         load_q, load_d;
  logic [W-1:0] addr_q, addr_d;
  logic         accept;
  logic         taken;
  logic [W-1:0] target;
  ras_cmd_e     ras_cmd;
  logic [W-1:0] ras_top;

  // The op presented while a redirect is being issued is wrong-path.
  assign accept = valid & ~load_q;

  always_comb begin
    taken   = 1'b0;
    target  = a;
    ras_cmd = RAS_NOP;
    if (accept) begin
      case (op)
        D16_OP_JMP: taken = 1'b1;
        D16_OP_JMZ: taken = (b == '0);
        D16_OP_JNZ: taken = (b != '0);
        D16_OP_JMN: taken = b[W-1];
        D16_OP_JMR: begin
          taken  = 1'b1;
          target = b;
        end
        D16_OP_CALL: begin
          taken   = 1'b1;
          ras_cmd = RAS_PUSH;
        end
        D16_OP_RET: begin
          // Pop is still issued when empty so the stack records the underflow.
          ras_cmd = RAS_POP;
          taken   = ~ras_empty;
          target  = ras_top;
        end
        default: ;
      endcase
    end
    load_d = taken;
    addr_d = taken ? target : '0;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      load_q <= 1'b0;
      addr_q <= '0;
    end else begin
      load_q <= load_d;
      addr_q <= addr_d;
    end
  end

  assign load      = load_q;
  assign mem_addr  = addr_q;
  assign li_di_rst = sys_rst | load_q;

  d16_ras #(
    .W     (W),
    .DEPTH (RAS_DEPTH),
    .AW    (RAS_AW)
  ) u_ras (
    .clk_i   (sys_clk),
    .srst_i  (sys_rst),
    .cmd_i   (ras_cmd),
    .data_i  (pc_next),
    .top_o   (ras_top),
    .empty_o (ras_empty),
    .full_o  (ras_full),
    .ovf_o   (ras_ovf),
    .unf_o   (ras_unf)
  );

endmodule

// File: tb/tb_d16_branch.sv
// Testbench for d16_branch: two instances (W=16/depth 8 and W=24/depth 4) run
// in lockstep against a list-based reference model of the branch rules.
module tb_d16_branch;
  import d16_branch_pkg::*;

  logic        clk = 1'b0;
  logic        rst, vld;
  logic [7:0]  op;
  logic [23:0] a, b, pcn;

  logic        li16, load16, emp16, full16, ovf16, unf16;
  logic [15:0] addr16;
  logic        li24, load24, emp24, full24, ovf24, unf24;
  logic [23:0] addr24;

  int checks = 0;
  int failures = 0;

  // Reference model state, index 0 = 16-bit/depth 8, index 1 = 24-bit/depth 4.
  // The stack is a plain list: entry 0 is the oldest, entry cnt-1 the top.
  logic [23:0] m_stk [2][8];
  int          m_cnt [2];
  bit          m_load [2];
  logic [23:0] m_addr [2];
  bit          m_ovf [2];
  bit          m_unf [2];
  bit          cur_rst;

  always #5 clk = ~clk;

  d16_branch #(.W(16), .RAS_DEPTH(8)) u_dut16 (
    .sys_clk(clk), .sys_rst(rst), .valid(vld), .op(op),
    .a(a[15:0]), .b(b[15:0]), .pc_next(pcn[15:0]),
    .li_di_rst(li16), .mem_addr(addr16), .load(load16),
    .ras_empty(emp16), .ras_full(full16), .ras_ovf(ovf16), .ras_unf(unf16)
  );

  d16_branch #(.W(24), .RAS_DEPTH(4)) u_dut24 (
    .sys_clk(clk), .sys_rst(rst), .valid(vld), .op(op),
    .a(a), .b(b), .pc_next(pcn),
    .li_di_rst(li24), .mem_addr(addr24), .load(load24),
    .ras_empty(emp24), .ras_full(full24), .ras_ovf(ovf24), .ras_unf(unf24)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input int w, input int depth, input bit r,
                            input bit v, input logic [7:0] o,
                            input logic [23:0] aa, input logic [23:0] bb,
                            input logic [23:0] pp);
    logic [23:0] msk;
    bit          tk;
    logic [23:0] tg;
    msk = (w == 16) ? 24'h00FFFF : 24'hFFFFFF;
    aa = aa & msk;
    bb = bb & msk;
    pp = pp & msk;
    if (r) begin
      m_load[k] = 0; m_addr[k] = '0; m_cnt[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
      return;
    end
    tk = 0;
    tg = aa;
    if (v && !m_load[k]) begin
      case (o)
        D16_OP_JMP: tk = 1;
        D16_OP_JMZ: tk = (bb == 0);
        D16_OP_JNZ: tk = (bb != 0);
        D16_OP_JMN: tk = bb[w-1];
        D16_OP_JMR: begin tk = 1; tg = bb; end
        D16_OP_CALL: begin
          tk = 1;
          if (m_cnt[k] == depth) begin
            for (int i = 0; i < depth - 1; i++) m_stk[k][i] = m_stk[k][i+1];
            m_stk[k][depth-1] = pp;
            m_ovf[k] = 1;
          end else begin
            m_stk[k][m_cnt[k]] = pp;
            m_cnt[k]++;
          end
        end
        D16_OP_RET: begin
          if (m_cnt[k] > 0) begin
            tk = 1;
            m_cnt[k]--;
            tg = m_stk[k][m_cnt[k]];
          end else begin
            m_unf[k] = 1;
          end
        end
        default: ;
      endcase
    end
    m_load[k] = tk;
    m_addr[k] = tk ? tg : '0;
  endtask

  task automatic check_all();
    chk("load16",  {31'b0, load16}, {31'b0, m_load[0]});
    chk("addr16",  {16'b0, addr16}, {8'b0, m_addr[0]});
    chk("flush16", {31'b0, li16},   {31'b0, cur_rst | m_load[0]});
    chk("empty16", {31'b0, emp16},  {31'b0, m_cnt[0] == 0});
    chk("full16",  {31'b0, full16}, {31'b0, m_cnt[0] == 8});
    chk("ovf16",   {31'b0, ovf16},  {31'b0, m_ovf[0]});
    chk("unf16",   {31'b0, unf16},  {31'b0, m_unf[0]});
    chk("load24",  {31'b0, load24}, {31'b0, m_load[1]});
    chk("addr24",  {8'b0, addr24},  {8'b0, m_addr[1]});
    chk("flush24", {31'b0, li24},   {31'b0, cur_rst | m_load[1]});
    chk("empty24", {31'b0, emp24},  {31'b0, m_cnt[1] == 0});
    chk("full24",  {31'b0, full24}, {31'b0, m_cnt[1] == 4});
    chk("ovf24",   {31'b0, ovf24},  {31'b0, m_ovf[1]});
    chk("unf24",   {31'b0, unf24},  {31'b0, m_unf[1]});
  endtask

  // One transaction: drive at negedge, advance the model, check after the edge.
  task automatic cyc(input bit r, input bit v, input logic [7:0] o,
                     input logic [23:0] aa, input logic [23:0] bb, input logic [23:0] pp);
    @(negedge clk);
    rst = r; vld = v; op = o; a = aa; b = bb; pcn = pp;
    cur_rst = r;
    model_step(0, 16, 8, r, v, o, aa, bb, pp);
    model_step(1, 24, 4, r, v, o, aa, bb, pp);
    @(posedge clk);
    #1;
    check_all();
    $display("txn rst=%0b vld=%0b op=%02h a=%06h b=%06h pc=%06h | load16=%0b addr16=%04h load24=%0b addr24=%06h",
             r, v, o, aa, bb, pp, load16, addr16, load24, addr24);
  endtask

  task automatic idle();
    cyc(0, 0, 8'h00, 0, 0, 0);
  endtask

  logic [7:0] ops [8];

  initial begin
    rst = 1; vld = 0; op = 0; a = 0; b = 0; pcn = 0; cur_rst = 1;
    ops[0] = D16_OP_JMP;  ops[1] = D16_OP_JMZ;  ops[2] = D16_OP_JNZ; ops[3] = D16_OP_JMN;
    ops[4] = D16_OP_JMR;  ops[5] = D16_OP_CALL; ops[6] = D16_OP_RET; ops[7] = 8'h00;

    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, D16_OP_JMP, 24'h55, 0, 0);
    chk("rst_load", {31'b0, load16}, 32'd0);
    chk("rst_empty", {31'b0, emp16}, 32'd1);
    idle();

    // JMZ taken
    cyc(0, 1, D16_OP_JMZ, 24'h0123, 24'h0, 0);
    chk("plan_jmz_addr", {16'b0, addr16}, 32'h0123);
    chk("plan_jmz_flush", {31'b0, li16}, 32'd1);
    idle();
    chk("plan_jmz_after", {31'b0, load16}, 32'd0);

    // JNZ/JMN not taken, JMN taken
    cyc(0, 1, D16_OP_JNZ, 24'h0100, 24'h0, 0);
    cyc(0, 1, D16_OP_JMN, 24'h0100, 24'h7FFF, 0);
    chk("plan_jmn_nt", {31'b0, load16}, 32'd0);
    cyc(0, 1, D16_OP_JMN, 24'h0040, 24'h8000, 0);
    chk("plan_jmn_t", {16'b0, addr16}, 32'h0040);
    idle();

    // CALL, shadow RET ignored, RET returns
    cyc(0, 1, D16_OP_CALL, 24'h0200, 0, 24'h0011);
    chk("plan_call", {16'b0, addr16}, 32'h0200);
    cyc(0, 1, D16_OP_RET, 0, 0, 0);
    cyc(0, 1, D16_OP_RET, 0, 0, 0);
    chk("plan_ret", {16'b0, addr16}, 32'h0011);
    idle();
    chk("plan_ret_empty", {31'b0, emp16}, 32'd1);

    // Overflow/underflow on the depth-4 instance
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 1, D16_OP_CALL, 24'h000300, 0, 24'(i));
      idle();
    end
    chk("plan_ovf24", {31'b0, ovf24}, 32'd1);
    chk("plan_full24", {31'b0, full24}, 32'd1);
    for (int i = 5; i >= 2; i--) begin
      cyc(0, 1, D16_OP_RET, 0, 0, 0);
      chk("plan_ret24", {8'b0, addr24}, 32'(i));
      idle();
    end
    cyc(0, 1, D16_OP_RET, 0, 0, 0);
    chk("plan_unf_load24", {31'b0, load24}, 32'd0);
    chk("plan_unf24", {31'b0, unf24}, 32'd1);
    idle();

    // Reset during a pending redirect
    cyc(0, 1, D16_OP_JMP, 24'h0777, 0, 0);
    cyc(1, 1, D16_OP_CALL, 24'h0888, 0, 24'h1);
    chk("plan_rst_load", {31'b0, load16}, 32'd0);
    chk("plan_rst_flush", {31'b0, li16}, 32'd1);
    chk("plan_rst_ovf24", {31'b0, ovf24}, 32'd0);
    chk("plan_rst_empty24", {31'b0, emp24}, 32'd1);
    idle();

    // Wide register-indirect jump
    cyc(0, 1, D16_OP_JMR, 0, 24'hABCDEF, 0);
    chk("plan_jmr24", {8'b0, addr24}, 32'hABCDEF);
    idle();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [23:0] rb;
      rb = ($urandom_range(0, 3) == 0) ? 24'h0 : 24'($urandom);
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
          ops[$urandom_range(0, 7)], 24'($urandom), rb, 24'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/d16_branch.md
# d16_branch

Parametrised branch/redirect unit for the d16 core with a hardware return-address stack (RAS). It resolves conditional jumps, register-indirect jumps, calls and returns, and drives a registered one-cycle redirect (fetch address + load + pipeline flush) into the fetch/decode stage. It replaces the single-width combinational jump decoder with a width-generic, registered unit that has call/return support and stack fault reporting.

## Interface
- `W`, 16, datapath/address width
- `RAS_DEPTH`, 8, return-stack entries; power of two, ≥2
- `RAS_AW`, derived localparam = log2(`RAS_DEPTH`), not overridable
- `sys_clk`  in  1  clock
- `sys_rst`  in  1  reset; **one clock; reset is synchronous and active-high**
- `valid`  in  1  `op`/`a`/`b`/`pc_next` are meaningful this cycle
- `op`  in  8  decoded opcode
- `a`  in  W  immediate target
- `b`  in  W  condition operand / register target
- `pc_next`  in  W  address of the instruction following this one (return address)
- `li_di_rst`  out  1  flush fetch/decode latches
- `mem_addr`  out  W  redirect fetch address
- `load`  out  1  PC load strobe
- `ras_empty`  out  1  stack holds 0 entries
- `ras_full`  out  1  stack holds `RAS_DEPTH` entries
- `ras_ovf`  out  1  sticky: push while full
- `ras_unf`  out  1  sticky: pop while empty

## Operation
- Accepted op = `valid & ~load` (the op presented during a redirect cycle is wrong-path and is ignored; it causes no stack update).
- Taken / target per accepted op:
  - JMP: taken, `a`. JMZ: taken if `b == 0`, `a`. JNZ: taken if `b != 0`, `a`. JMN: taken if `b[W-1]`, `a`. JMR: taken, `b`.
  - CALL: taken, `a`; push `pc_next`.
  - RET: if not empty, taken, target = top entry, pop; if empty, not taken, set `ras_unf`.
  - Any other opcode: not taken, no stack effect.
- RAS: circular array, `sp` (RAS_AW bits, wraps mod `RAS_DEPTH`) points at the next free slot, `count` 0..`RAS_DEPTH`.
  - Push while full: overwrite oldest slot, `sp` advances, `count` stays `RAS_DEPTH`, set `ras_ovf`.
  - Pop: top = entry[`sp`-1]; `sp` decrements, `count` decrements.
- Sticky flags clear only on `sys_rst`.

## Timing
- Op accepted at edge N → `load`, `mem_addr` valid during cycle N+1 for exactly one cycle; latency 1.
- `mem_addr` = 0 whenever `load` = 0.
- `li_di_rst` = `sys_rst | load_q` (combinational OR, so flush is held throughout reset).
- Stack update commits at edge N; an op accepted at N+1 sees the updated stack. CALL at N is followed by a shadow cycle (N+1, ignored), so RET is first accepted at N+2 and returns `pc_next` of that CALL.
- Not-taken ops: no output pulse; the next cycle is not a shadow cycle.
- Reset (sampled at an edge): `load`=0, `mem_addr`=0, `sp`=0, `count`=0, `ras_ovf`=`ras_unf`=0, `ras_empty`=1, `ras_full`=0; stack contents are don't-care. Reset during a pending redirect cancels it; any op presented with reset is discarded.

## Structure
- New opcode constants `D16_OP_JNZ`, `D16_OP_JMN`, `D16_OP_CALL`, `D16_OP_RET` are added to the shared `d16.vh` next to the existing JMP/JMZ/JMR constants; no local opcode literals.
- One sub-module, `d16_ras` (parametrised circular stack: push, pop, top, empty/full, ovf/unf); `d16_branch` holds the condition decode and the redirect registers.

## Test plan
- Reset, then `valid`=1 JMZ `a`=0x0123 `b`=0 → next cycle `load`=1, `mem_addr`=0x0123, `li_di_rst`=1; following cycle all 0.
- JNZ `b`=0, then JMN `b`=0x7FFF → no `load` pulses; JMN `b`=0x8000 `a`=0x0040 → redirect to 0x0040.
- CALL `a`=0x0200 `pc_next`=0x0011; shadow cycle presents RET (must be ignored); RET next → redirect 0x0200, then 0x0011; `ras_empty`=1 at the end.
- `RAS_DEPTH`=4: 5 CALLs (`pc_next` 1..5) → `ras_ovf`=1, `ras_full`=1; 4 RETs return 5,4,3,2; 5th RET → no `load`, `ras_unf`=1.
- Assert `sys_rst` in the cycle after an accepted JMP → `load`=0, `li_di_rst`=1, flags cleared, `ras_empty`=1.
- Sweep `W`=24 with JMR `b`=0xABCDEF → `mem_addr`=0xABCDEF.
